// File: rtl/pll_dyn_ctrl.sv
// Run-time controller for a Gowin rPLL in dynamic-divider mode: drives the
// divider selects and RESET, filters LOCK, and sequences reset/retry.
module pll_dyn_ctrl #(
    parameter logic [5:0]  DEF_IDSEL    = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL   = 6'd0,
    parameter logic [5:0]  DEF_ODSEL    = 6'd0,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       req,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    output logic       ready,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       rst_out_n,
    output logic       done,
    output logic       error,
    output logic [7:0] lol_cnt
);

    localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [RST_W-1:0]  cnt_q, cnt_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [7:0]        lol_q, lol_d;
    logic [5:0]        idsel_q, idsel_d;
    logic [5:0]        fbdsel_q, fbdsel_d;
    logic [5:0]        odsel_q, odsel_d;
    logic              pll_reset_q, pll_reset_d;
    logic              locked_q, locked_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        sync_q;
    logic              lk_s;

    // LOCK synchroniser; held clear during RST so a stale lock never counts
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else if (state_q == S_RST) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lk_s = sync_q[1];

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            filt_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            lol_q       <= '0;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            lol_q       <= lol_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        lol_d    = lol_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;

        case (state_q)
            S_RST: begin
                filt_d = '0;
                tmo_d  = '0;
                if (cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + RST_W'(1);
                end
            end
            S_WAIT: begin
                filt_d = lk_s ? filt_q + FILT_W'(1) : '0;
                if (tmo_q != TMO_W'(LOCK_TIMEOUT)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                // A lock completing on the timeout cycle wins over the timeout
                if (filt_d == FILT_W'(LOCK_FILTER)) begin
                    state_d = S_RUN;
                end else if (tmo_d == TMO_W'(LOCK_TIMEOUT)) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_d < RTY_W'(MAX_RETRY)) ? S_RST : S_FAIL;
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    if (lol_q != 8'hFF) begin
                        lol_d = lol_q + 8'd1;
                    end
                    retry_d = '0;
                    state_d = S_RST;
                end else if (req) begin
                    idsel_d  = req_idsel;
                    fbdsel_d = req_fbdsel;
                    odsel_d  = req_odsel;
                    retry_d  = '0;
                    state_d  = S_RST;
                end
            end
            S_FAIL: begin
                if (req) begin
                    idsel_d  = req_idsel;
                    fbdsel_d = req_fbdsel;
                    odsel_d  = req_odsel;
                    retry_d  = '0;
                    state_d  = S_RST;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        pll_reset_d = (state_d == S_RST);
        locked_d    = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN) || (state_d == S_FAIL);
        error_d     = (state_d == S_FAIL);
        done_d      = (state_d == S_RUN) && (state_q != S_RUN);
    end

    assign ready      = ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign rst_out_n  = locked_q;
    assign done       = done_q;
    assign error      = error_q;
    assign lol_cnt    = lol_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: power-up, reconfigure, glitch, timeout,
// lock loss and asynchronous reset, with hand-computed cycle counts.
module tb_pll_dyn_ctrl;

    localparam logic [5:0] DI = 6'd1;
    localparam logic [5:0] DF = 6'd2;
    localparam logic [5:0] DO = 6'd4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       req      = 1'b0;
    logic       pll_lock = 1'b1;
    logic [5:0] ri       = 6'd0;
    logic [5:0] rf       = 6'd0;
    logic [5:0] ro       = 6'd0;

    logic       ready, pll_reset, locked, rst_out_n, done, error;
    logic [5:0] pi, pf, po;
    logic [7:0] lol_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_dyn_ctrl #(
        .DEF_IDSEL   (DI),
        .DEF_FBDSEL  (DF),
        .DEF_ODSEL   (DO),
        .RESET_CYCLES(4),
        .LOCK_FILTER (8),
        .LOCK_TIMEOUT(100),
        .MAX_RETRY   (2)
    ) dut (
        .clkin     (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_idsel (ri),
        .req_fbdsel(rf),
        .req_odsel (ro),
        .ready     (ready),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pi),
        .pll_fbdsel(pf),
        .pll_odsel (po),
        .locked    (locked),
        .rst_out_n (rst_out_n),
        .done      (done),
        .error     (error),
        .lol_cnt   (lol_cnt)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (locked !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({pll_reset, locked, ready, error, done, rst_out_n} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b want 100000",
                     {pll_reset, locked, ready, error, done, rst_out_n});
        end
        checks++;
        if ({pi, pf, po} !== {DI, DF, DO} || lol_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs got sel %0d/%0d/%0d lol %0d want %0d/%0d/%0d lol 0",
                     pi, pf, po, lol_cnt, DI, DF, DO);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        int n;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pll_reset !== 1'b1) begin
                errors++;
                $display("FAIL pwr_rst_hi cycle %0d got %b want 1", i, pll_reset);
            end
            step();
        end
        checks++;
        if (pll_reset !== 1'b0) begin
            errors++;
            $display("FAIL pwr_rst_lo got %b want 0", pll_reset);
        end
        wait_locked(50, n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL pwr_lock_latency got %0d want 10", n);
        end
        checks++;
        if ({done, ready, error, rst_out_n} !== 4'b1101) begin
            errors++;
            $display("FAIL pwr_run_flags got %b want 1101", {done, ready, error, rst_out_n});
        end
        checks++;
        if ({pi, pf, po} !== {DI, DF, DO}) begin
            errors++;
            $display("FAIL pwr_sel got %0d/%0d/%0d want %0d/%0d/%0d", pi, pf, po, DI, DF, DO);
        end
        step();
        checks++;
        if ({done, locked} !== 2'b01) begin
            errors++;
            $display("FAIL pwr_done_pulse got %b want 01", {done, locked});
        end
    endtask

    task automatic test_reconfig();
        int n;
        req = 1'b1; ri = 6'd3; rf = 6'd9; ro = 6'd8;
        step();
        req = 1'b0; ri = 6'd63; rf = 6'd63; ro = 6'd63;
        checks++;
        if ({pll_reset, locked, ready, rst_out_n} !== 4'b1000) begin
            errors++;
            $display("FAIL cfg_accept_flags got %b want 1000",
                     {pll_reset, locked, ready, rst_out_n});
        end
        checks++;
        if ({pi, pf, po} !== {6'd3, 6'd9, 6'd8}) begin
            errors++;
            $display("FAIL cfg_accept_sel got %0d/%0d/%0d want 3/9/8", pi, pf, po);
        end
        wait_locked(50, n);
        checks++;
        if (n !== 14 || done !== 1'b1) begin
            errors++;
            $display("FAIL cfg_relock got %0d done %b want 14 done 1", n, done);
        end
        checks++;
        if ({pi, pf, po} !== {6'd3, 6'd9, 6'd8}) begin
            errors++;
            $display("FAIL cfg_hold_sel got %0d/%0d/%0d want 3/9/8", pi, pf, po);
        end
    endtask

    task automatic test_glitch();
        int n;
        req = 1'b1; pll_lock = 1'b0; ri = 6'd5; rf = 6'd6; ro = 6'd7;
        step();
        req = 1'b0;
        repeat (4) step();
        checks++;
        if ({pll_reset, locked} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_in_wait got %b want 00", {pll_reset, locked});
        end
        pll_lock = 1'b1;
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_locked(20, n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL glitch_lock_latency got %0d want 10", n);
        end
        checks++;
        if ({pi, pf, po} !== {6'd5, 6'd6, 6'd7}) begin
            errors++;
            $display("FAIL glitch_sel got %0d/%0d/%0d want 5/6/7", pi, pf, po);
        end
    endtask

    task automatic test_timeout();
        int n;
        int rise;
        logic prev;
        req = 1'b1; pll_lock = 1'b0; ri = 6'd2; rf = 6'd3; ro = 6'd4;
        step();
        req = 1'b0;
        n = 0;
        rise = 0;
        prev = pll_reset;
        while (error !== 1'b1 && n < 300) begin
            step();
            n++;
            if (prev === 1'b0 && pll_reset === 1'b1 && rise == 0) rise = n;
            prev = pll_reset;
        end
        checks++;
        if (rise !== 104) begin
            errors++;
            $display("FAIL tmo_retry_edge got %0d want 104", rise);
        end
        checks++;
        if (n !== 208) begin
            errors++;
            $display("FAIL tmo_fail_edge got %0d want 208", n);
        end
        checks++;
        if ({error, ready, pll_reset, locked} !== 4'b1100) begin
            errors++;
            $display("FAIL tmo_fail_flags got %b want 1100", {error, ready, pll_reset, locked});
        end
        req = 1'b1; pll_lock = 1'b1; ri = 6'd10; rf = 6'd11; ro = 6'd12;
        step();
        req = 1'b0;
        checks++;
        if ({error, pll_reset, ready} !== 3'b010) begin
            errors++;
            $display("FAIL tmo_recover_flags got %b want 010", {error, pll_reset, ready});
        end
        checks++;
        if ({pi, pf, po} !== {6'd10, 6'd11, 6'd12}) begin
            errors++;
            $display("FAIL tmo_recover_sel got %0d/%0d/%0d want 10/11/12", pi, pf, po);
        end
        wait_locked(50, n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL tmo_relock got %0d want 14", n);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        for (int k = 1; k <= 3; k++) begin
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            checks++;
            if (rst_out_n !== 1'b1) begin
                errors++;
                $display("FAIL lol_edge1 event %0d got %b want 1", k, rst_out_n);
            end
            step();
            checks++;
            if (rst_out_n !== 1'b1) begin
                errors++;
                $display("FAIL lol_edge2 event %0d got %b want 1", k, rst_out_n);
            end
            step();
            checks++;
            if ({rst_out_n, pll_reset} !== 2'b01) begin
                errors++;
                $display("FAIL lol_edge3 event %0d got %b want 01", k, {rst_out_n, pll_reset});
            end
            checks++;
            if (lol_cnt !== 8'(k)) begin
                errors++;
                $display("FAIL lol_count got %0d want %0d", lol_cnt, k);
            end
            wait_locked(50, n);
            checks++;
            if (n !== 14) begin
                errors++;
                $display("FAIL lol_relock event %0d got %0d want 14", k, n);
            end
            checks++;
            if ({pi, pf, po} !== {6'd10, 6'd11, 6'd12}) begin
                errors++;
                $display("FAIL lol_sel got %0d/%0d/%0d want 10/11/12", pi, pf, po);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 1'b1; pll_lock = 1'b0; ri = 6'd20; rf = 6'd21; ro = 6'd22;
        step();
        req = 1'b0;
        repeat (6) step();
        checks++;
        if ({pll_reset, locked} !== 2'b00 || lol_cnt !== 8'd3) begin
            errors++;
            $display("FAIL arst_pre got %b lol %0d want 00 lol 3", {pll_reset, locked}, lol_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_reset, locked, ready, error, done, rst_out_n} !== 6'b100000) begin
            errors++;
            $display("FAIL arst_flags got %b want 100000",
                     {pll_reset, locked, ready, error, done, rst_out_n});
        end
        checks++;
        if ({pi, pf, po} !== {DI, DF, DO} || lol_cnt !== 8'd0) begin
            errors++;
            $display("FAIL arst_regs got sel %0d/%0d/%0d lol %0d want %0d/%0d/%0d lol 0",
                     pi, pf, po, lol_cnt, DI, DF, DO);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_reconfig();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_dyn_ctrl.md
# pll_dyn_ctrl

Run-time controller for a Gowin rPLL in dynamic-divider mode. It drives the PLL's IDSEL/FBDSEL/ODSEL select buses and RESET, and filters the raw LOCK output. It sequences PLL resets with timeout and retry, and holds a reset for the downstream clock domain until lock is stable. It sits next to the rPLL instance on the PLL input clock and lets the design change output frequency without a rebuild.

## Interface
Parameters:
- DEF_IDSEL, 6'd0: pll_idsel value after reset.
- DEF_FBDSEL, 6'd0: pll_fbdsel value after reset.
- DEF_ODSEL, 6'd0: pll_odsel value after reset.
- RESET_CYCLES, 16: number of cycles pll_reset is held high per attempt (≥2).
- LOCK_FILTER, 256: consecutive synchronised lock-high cycles required to declare lock (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before an attempt fails.
- MAX_RETRY, 3: failed attempts allowed before entering FAIL (≥1).

Ports:
- clkin, in, 1: PLL reference clock; the whole block runs on it.
- rst_n, in, 1: asynchronous active-low reset.
- req, in, 1: reconfiguration request; accepted when req && ready.
- req_idsel, in, 6: new IDSEL code; latched on accept.
- req_fbdsel, in, 6: new FBDSEL code; latched on accept.
- req_odsel, in, 6: new ODSEL code; latched on accept.
- ready, out, 1: block can accept req (state RUN or FAIL).
- pll_lock, in, 1: raw LOCK from the rPLL; asynchronous.
- pll_reset, out, 1: to rPLL RESET.
- pll_idsel, out, 6: to rPLL IDSEL, passed through unmodified.
- pll_fbdsel, out, 6: to rPLL FBDSEL, passed through unmodified.
- pll_odsel, out, 6: to rPLL ODSEL, passed through unmodified.
- locked, out, 1: filtered lock; high only in RUN.
- rst_out_n, out, 1: downstream domain reset; equals locked.
- done, out, 1: one-cycle pulse on each entry to RUN.
- error, out, 1: high while in FAIL.
- lol_cnt, out, 8: count of lock-loss events in RUN, saturating at 255.

## Operation
- pll_lock passes through a 2-FF synchroniser to produce lk_s. Only lk_s is used internally.
- States and transitions:
  - RST: pll_reset=1. Counter runs 0..RESET_CYCLES-1, then go to WAIT_LOCK. The filter and timeout counters are cleared on entry.
  - WAIT_LOCK: pll_reset=0.
    - Filter counter increments while lk_s=1 and clears to 0 on lk_s=0.
    - On reaching LOCK_FILTER: go to RUN and pulse done.
    - Timeout counter increments every cycle. On reaching LOCK_TIMEOUT with no lock, increment retry.
    - If retry < MAX_RETRY after the increment, go to RST; otherwise go to FAIL.
  - RUN: locked=1, ready=1.
    - lk_s=0 takes priority over req: lol_cnt saturating-increments and the block goes to RST. Select codes are unchanged and retry is cleared.
    - Otherwise req=1 latches the three req_* codes onto the pll_*sel outputs, clears retry, and the block goes to RST.
  - FAIL: error=1, ready=1, pll_reset=0. On req: latch codes, clear retry, go to RST.
- Select outputs change only on an accepted req. They are stable throughout RST and WAIT_LOCK.
- Counter widths are $clog2(param+1). The timeout counter does not wrap.

## Timing
- Reset values (rst_n low, asynchronous):
  - state=RST, counter=0
  - pll_reset=1, pll_*sel=DEF_*
  - locked=0, rst_out_n=0, ready=0, done=0, error=0
  - lol_cnt=0, retry=0, synchroniser=0
- After rst_n rises, pll_reset stays high for exactly RESET_CYCLES clkin edges.
- Lock latency: a pll_lock rise that holds steady sets locked at edge 2+LOCK_FILTER after the first WAIT_LOCK cycle in which the rise is sampled. done is high in that same cycle.
- Accept to pll_reset: pll_reset=1 and the new codes appear on the edge that accepts req. locked, ready and rst_out_n drop on that same edge.
- Lock loss to reset: rst_out_n drops on the edge after lk_s is sampled low, i.e. 3 edges after pll_lock falls.
- A req held through RST and WAIT_LOCK is ignored (ready=0). It is accepted on the first RUN cycle only if still high, and done still pulses on that RUN entry.
- A lk_s glitch low inside WAIT_LOCK restarts the filter but not the timeout.

## Test plan
Bench parameters for all scenarios: RESET_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
- Power-up: release rst_n with pll_lock=1 held → pll_reset high for 4 cycles. locked rises 10 cycles after WAIT_LOCK entry, done pulses once, and pll_*sel equal DEF_*.
- Reconfigure: in RUN, pulse req with idsel=3, fbdsel=9, odsel=8 → codes appear and pll_reset=1 on the accept edge, locked=0. The block relocks after stable lock, and the codes stay at 3/9/8.
- Glitchy lock: in WAIT_LOCK, drive pll_lock high 5 cycles, low 1, high 20 → locked rises only after 8 consecutive synchronised highs.
- Timeout/retry: pll_lock held 0 → two RST/WAIT_LOCK attempts of 100 cycles each, then error=1 and ready=1. A req then returns the block to RST with error=0.
- Lock loss: in RUN, drop pll_lock 1 cycle three times → lol_cnt=3, rst_out_n low within 3 cycles each time, full reset sequence rerun each time.
- Async reset mid-WAIT_LOCK: assert rst_n → all outputs take their reset values immediately, without a clock edge, and lol_cnt returns to 0.
